vga_timing_gen: RTL

Parametrised VGA raster timing generator with an aligned RGB332 output stage. It replaces the fixed 640x480 timing logic inside the game display path. It derives a pixel-tick enable from the system clock and presents pixel coordinates and a request to an upstream pixel source. It delays the syncs to match the source's pipeline latency and blanks colour outside the active area. A frame-synchronous enable lets the display start and stop cleanly on frame boundaries.

---
 rtl/vga_timing_gen.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator with pixel-tick
//                divider, frame-synchronous enable and an RGB332 output
//                stage aligned to the pixel source's pipeline latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned PIPE     = 2,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned FC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       r_in,
    input  logic [2:0]       g_in,
    input  logic [1:0]       b_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             req,
    output logic             tick,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt,
    output logic [2:0]       r,
    output logic [2:0]       g,
    output logic [1:0]       b,
    output logic             de,
    output logic             hs,
    output logic             vs
);

    localparam int unsigned c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0]   c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0]   c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]   c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]   c_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0]   c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0]   c_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0]   c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;
    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_v;
    logic               w_h_last;
    logic               w_v_last;
    logic               w_frame_end;
    logic               w_counting;
    logic               w_active;
    logic               w_hsync_raw;
    logic               w_vsync_raw;
    logic               w_line_start;
    logic               w_frame_start;
    logic [FC_W-1:0]    r_frame_cnt;
    logic [2:0]         w_raw;
    logic [2:0]         w_last_in;
    logic               r_de;
    logic               r_hsync_d;
    logic               r_vsync_d;
    logic [2:0]         r_r;
    logic [2:0]         r_g;
    logic [1:0]         r_b;

    // Pixel-tick divider, free-running in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_tick = (r_div_cnt == c_DIV_LAST);

    assign w_h_last    = (r_h == c_H_LAST);
    assign w_v_last    = (r_v == c_V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_counting  = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Enable is honoured only on ticks; a draining frame always runs to its wrap
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_frame_end) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (!w_counting) begin
                r_h <= '0;
                r_v <= '0;
            end else if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign w_active    = w_counting && (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hsync_raw = w_counting && (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vsync_raw = w_counting && (r_v >= c_VS_BEG) && (r_v < c_VS_END);

    assign w_line_start  = w_tick && w_counting && (r_h == '0);
    assign w_frame_start = w_line_start && (r_v == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Raw timing enters the delay line at the end of the tick it describes
    assign w_raw = {w_active, w_hsync_raw, w_vsync_raw};

    generate
        if (PIPE == 1) begin : g_pipe_single
            assign w_last_in = w_raw;
        end else begin : g_pipe_multi
            logic [2:0] r_dly [PIPE-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(PIPE) - 1; i++) begin
                        r_dly[i] <= '0;
                    end
                end else if (w_tick) begin
                    r_dly[0] <= w_raw;
                    for (int i = 1; i < int'(PIPE) - 1; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_last_in = r_dly[PIPE-2];
        end
    endgenerate

    // Final stage captures the source colour on the same edge as de
    always_ff @(posedge clk) begin
        if (rst) begin
            r_de      <= 1'b0;
            r_hsync_d <= 1'b0;
            r_vsync_d <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else if (w_tick) begin
            r_de      <= w_last_in[2];
            r_hsync_d <= w_last_in[1];
            r_vsync_d <= w_last_in[0];
            r_r       <= w_last_in[2] ? r_in : 3'd0;
            r_g       <= w_last_in[2] ? g_in : 3'd0;
            r_b       <= w_last_in[2] ? b_in : 2'd0;
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign req         = w_active;
    assign tick        = w_tick;
    assign line_start  = w_line_start;
    assign frame_start = w_frame_start;
    assign frame_cnt   = r_frame_cnt;
    assign de          = r_de;
    assign r           = r_r;
    assign g           = r_g;
    assign b           = r_b;
    assign hs          = r_hsync_d ? HS_POL : ~HS_POL;
    assign vs          = r_vsync_d ? VS_POL : ~VS_POL;

endmodule
`default_nettype wire
